shift_op_sequencer: RTL and testbench

//  Initiator side of the ALU shift-unit interface. Accepts a multi-bit shift command over a

---
 rtl/shift_seq_pkg.sv | 21 ++
 rtl/shift_seq_step_cnt.sv | 29 ++
 rtl/shift_op_sequencer.sv | 146 ++++++++++++++
 tb/tb_shift_op_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and command encodings for the shift-operation sequencer.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam logic [1:0] FUN_A_SHR = 2'b00;
  localparam logic [1:0] FUN_A_SHL = 2'b01;
  localparam logic [1:0] FUN_B_SHR = 2'b10;
  localparam logic [1:0] FUN_B_SHL = 2'b11;

  // Operand travels on B for FUN 1x, on A for FUN 0x.
  function automatic logic fun_uses_b(input logic [1:0] fun);
    return fun[1];
  endfunction

endpackage

// File: rtl/shift_seq_step_cnt.sv
// Step counter: loads the shift amount, decrements per completed step.
module shift_seq_step_cnt #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero,
  output logic             o_last
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);
  assign o_last = (r_count == CNT_W'(1));

endmodule

// File: rtl/shift_op_sequencer.sv
// Drives a single-bit ALU shift unit step by step to perform an N-bit shift command,
// feeding each SHIFT_OUT back as the next operand and returning the final value.
module shift_op_sequencer
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned CNT_W   = 5,
  parameter int unsigned TIMEOUT = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd_fun,
  input  logic [WIDTH-1:0] i_cmd_data,
  input  logic [CNT_W-1:0] i_cmd_count,
  output logic             o_shift_enable,
  output logic [1:0]       o_alu_fun,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b,
  input  logic [WIDTH-1:0] i_shift_out,
  input  logic             i_shift_flag,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [WIDTH-1:0] o_res_data,
  output logic             o_res_err
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  state_e           r_state;
  logic [1:0]       r_fun;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_shift_en;
  logic             r_res_valid;
  logic             r_res_err;
  logic [TMO_W-1:0] r_tmo;

  logic w_accept;
  logic w_step_done;
  logic w_cnt_zero;
  logic w_cnt_last;
  logic w_cnt_big;

  assign o_cmd_ready = (r_state == StIdle);
  assign w_accept    = o_cmd_ready && i_cmd_valid;
  assign w_step_done = (r_state == StWait) && i_shift_flag;
  // Shifting by WIDTH or more clears the operand, so no steps are issued.
  assign w_cnt_big   = (32'(i_cmd_count) >= WIDTH);

  shift_seq_step_cnt #(
    .CNT_W (CNT_W)
  ) u_step_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_accept),
    .i_load_val (i_cmd_count),
    .i_dec      (w_step_done),
    .o_zero     (w_cnt_zero),
    .o_last     (w_cnt_last)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_fun       <= '0;
      r_work      <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_shift_en  <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_err   <= 1'b0;
      r_tmo       <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_cmd_valid) begin
            r_fun <= i_cmd_fun;
            r_tmo <= '0;
            if (i_cmd_count == '0) begin
              r_work  <= i_cmd_data;
              r_state <= StDone;
            end else if (w_cnt_big) begin
              r_work  <= '0;
              r_state <= StDone;
            end else begin
              r_work     <= i_cmd_data;
              r_shift_en <= 1'b1;
              r_a        <= fun_uses_b(i_cmd_fun) ? '0 : i_cmd_data;
              r_b        <= fun_uses_b(i_cmd_fun) ? i_cmd_data : '0;
              r_state    <= StIssue;
            end
          end
        end
        StIssue: begin
          r_shift_en <= 1'b0;
          r_tmo      <= '0;
          r_state    <= StWait;
        end
        StWait: begin
          if (i_shift_flag && !w_cnt_zero) begin
            r_work <= i_shift_out;
            r_tmo  <= '0;
            if (w_cnt_last) begin
              r_res_valid <= 1'b1;
              r_state     <= StDone;
            end else begin
              r_shift_en <= 1'b1;
              r_a        <= fun_uses_b(r_fun) ? '0 : i_shift_out;
              r_b        <= fun_uses_b(r_fun) ? i_shift_out : '0;
              r_state    <= StIssue;
            end
          end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
            r_res_err   <= 1'b1;
            r_res_valid <= 1'b1;
            r_state     <= StDone;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        StDone: begin
          // Immediate (no-issue) commands arrive here with valid still low.
          if (!r_res_valid) begin
            r_res_valid <= 1'b1;
          end else if (i_res_ready) begin
            r_res_valid <= 1'b0;
            r_res_err   <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_shift_enable = r_shift_en;
  assign o_alu_fun      = r_fun;
  assign o_a            = r_a;
  assign o_b            = r_b;
  assign o_res_valid    = r_res_valid;
  assign o_res_data     = r_work;
  assign o_res_err      = r_res_err;

endmodule

// File: tb/tb_shift_op_sequencer.sv
// Directed bench for shift_op_sequencer with a behavioural single-bit shift unit.
module tb_shift_op_sequencer;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_fun = 2'b00;
  logic [WIDTH-1:0] cmd_data = '0;
  logic [CNT_W-1:0] cmd_count = '0;
  logic             shift_enable;
  logic [1:0]       alu_fun;
  logic [WIDTH-1:0] a_bus;
  logic [WIDTH-1:0] b_bus;
  logic [WIDTH-1:0] shift_out = '0;
  logic             shift_flag = 1'b0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [WIDTH-1:0] res_data;
  logic             res_err;

  logic             model_stall = 1'b0;
  int               n_vec = 0;
  int               n_err = 0;
  int               issue_cnt = 0;
  int               bad_bus = 0;
  logic [WIDTH-1:0] first_a = '0;
  logic [WIDTH-1:0] first_b = '0;
  int               lat;

  always #5 clk = ~clk;

  shift_op_sequencer #(
    .WIDTH   (WIDTH),
    .CNT_W   (CNT_W),
    .TIMEOUT (4)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_cmd_valid    (cmd_valid),
    .o_cmd_ready    (cmd_ready),
    .i_cmd_fun      (cmd_fun),
    .i_cmd_data     (cmd_data),
    .i_cmd_count    (cmd_count),
    .o_shift_enable (shift_enable),
    .o_alu_fun      (alu_fun),
    .o_a            (a_bus),
    .o_b            (b_bus),
    .i_shift_out    (shift_out),
    .i_shift_flag   (shift_flag),
    .o_res_valid    (res_valid),
    .i_res_ready    (res_ready),
    .o_res_data     (res_data),
    .o_res_err      (res_err)
  );

  // Registered single-bit shift unit: result and flag one cycle after enable.
  always @(posedge clk) begin
    if (rst) begin
      shift_flag <= 1'b0;
    end else if (shift_enable && !model_stall) begin
      shift_flag <= 1'b1;
      case (alu_fun)
        2'b00:   shift_out <= a_bus >> 1;
        2'b01:   shift_out <= a_bus << 1;
        2'b10:   shift_out <= b_bus >> 1;
        default: shift_out <= b_bus << 1;
      endcase
    end else begin
      shift_flag <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (shift_enable) begin
      if (issue_cnt == 0) begin
        first_a = a_bus;
        first_b = b_bus;
      end
      if ((alu_fun[1] && a_bus != '0) || (!alu_fun[1] && b_bus != '0)) bad_bus = bad_bus + 1;
      issue_cnt = issue_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    assert (obs === exp)
    else begin
      n_err = n_err + 1;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents a command at a negedge; returns at the negedge after the accept edge.
  task automatic send_cmd(input logic [1:0] fun, input logic [WIDTH-1:0] data,
                          input logic [CNT_W-1:0] cnt);
    int waited;
    waited = 0;
    while (!cmd_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("cmd_ready_before_send", 32'(cmd_ready), 32'd1);
    issue_cnt = 0;
    bad_bus   = 0;
    cmd_fun   = fun;
    cmd_data  = data;
    cmd_count = cnt;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Cycles from the accept edge until res_valid is seen (bounded).
  task automatic wait_result(output int cycles);
    cycles = 0;
    while (!res_valid && cycles < 60) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic take_result;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_shift_en", 32'(shift_enable), 32'd0);
    check("rst_alu_fun", 32'(alu_fun), 32'd0);
    check("rst_a", 32'(a_bus), 32'd0);
    check("rst_b", 32'(b_bus), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_res_err", 32'(res_err), 32'd0);

    // A >> 3
    send_cmd(2'b00, 16'h8001, 5'd3);
    wait_result(lat);
    check("t1_latency", 32'(lat), 32'd6);
    check("t1_data", 32'(res_data), 32'h1000);
    check("t1_err", 32'(res_err), 32'd0);
    check("t1_issues", 32'(issue_cnt), 32'd3);
    take_result;
    check("t1_valid_cleared", 32'(res_valid), 32'd0);

    // B << 4
    send_cmd(2'b11, 16'h0F0F, 5'd4);
    wait_result(lat);
    check("t2_latency", 32'(lat), 32'd8);
    check("t2_data", 32'(res_data), 32'hF0F0);
    check("t2_issues", 32'(issue_cnt), 32'd4);
    check("t2_first_a", 32'(first_a), 32'h0000);
    check("t2_first_b", 32'(first_b), 32'h0F0F);
    check("t2_bad_bus", 32'(bad_bus), 32'd0);
    check("t2_alu_fun", 32'(alu_fun), 32'd3);
    take_result;

    // N = 0 and N = WIDTH complete without issuing
    send_cmd(2'b01, 16'h1234, 5'd0);
    wait_result(lat);
    check("t3a_latency", 32'(lat), 32'd1);
    check("t3a_data", 32'(res_data), 32'h1234);
    check("t3a_issues", 32'(issue_cnt), 32'd0);
    take_result;
    send_cmd(2'b10, 16'hFFFF, 5'd16);
    wait_result(lat);
    check("t3b_latency", 32'(lat), 32'd1);
    check("t3b_data", 32'(res_data), 32'h0000);
    check("t3b_issues", 32'(issue_cnt), 32'd0);
    take_result;

    // Shift unit never answers: timeout
    model_stall = 1'b1;
    send_cmd(2'b10, 16'hABCD, 5'd2);
    wait_result(lat);
    check("t4_latency", 32'(lat), 32'd5);
    check("t4_err", 32'(res_err), 32'd1);
    check("t4_data", 32'(res_data), 32'hABCD);
    check("t4_issues", 32'(issue_cnt), 32'd1);
    take_result;
    check("t4_err_cleared", 32'(res_err), 32'd0);
    model_stall = 1'b0;

    // Result back-pressure, then a command queued during DONE
    send_cmd(2'b01, 16'h0001, 5'd1);
    wait_result(lat);
    check("t5_latency", 32'(lat), 32'd2);
    cmd_fun   = 2'b00;
    cmd_data  = 16'h0100;
    cmd_count = 5'd2;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_hold_valid", 32'(res_valid), 32'd1);
      check("t5_hold_data", 32'(res_data), 32'h0002);
      check("t5_hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    issue_cnt = 0;
    take_result;
    check("t5_hs_valid", 32'(res_valid), 32'd0);
    check("t5_hs_cmd_ready", 32'(cmd_ready), 32'd1);
    check("t5_hs_no_issue", 32'(shift_enable), 32'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("t5_accept_issue", 32'(shift_enable), 32'd1);
    check("t5_accept_busy", 32'(cmd_ready), 32'd0);
    wait_result(lat);
    check("t5b_latency", 32'(lat), 32'd4);
    check("t5b_data", 32'(res_data), 32'h0040);
    take_result;

    // Reset during WAIT aborts; next command still works
    send_cmd(2'b01, 16'h0003, 5'd5);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst_shift_en", 32'(shift_enable), 32'd0);
    check("t6_rst_valid", 32'(res_valid), 32'd0);
    check("t6_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (3) @(negedge clk);
    check("t6_no_result", 32'(res_valid), 32'd0);
    send_cmd(2'b01, 16'h0003, 5'd5);
    wait_result(lat);
    check("t6_latency", 32'(lat), 32'd10);
    check("t6_data", 32'(res_data), 32'h0060);
    check("t6_err", 32'(res_err), 32'd0);
    take_result;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
